// File: rtl/button_cond_pkg.sv
// Shared types and helpers for the push-button conditioner.
package button_cond_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMING  = 2'd1,
    PRESSED = 2'd2,
    DISARM  = 2'd3
  } state_t;

  // Counter width that stays legal for tiny or zero terminal values.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Pin-side and lights-side signals of the button conditioner.
interface button_conditioner_if;
  logic button_raw_i;
  logic button_o;
  logic press_o;
  logic release_o;
  logic button_step_o;

  modport slave (
    input  button_raw_i,
    output button_o, press_o, release_o, button_step_o
  );

  modport master (
    output button_raw_i,
    input  button_o, press_o, release_o, button_step_o
  );
endinterface

// File: rtl/button_conditioner_sync_nff.sv
// N-flop synchroniser for an asynchronous single-bit input, cleared by reset.
module sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/button_conditioner.sv
// Synchronises and debounces a push-button; emits level, press/release pulses
// and a rate-limited step strobe for the downstream lights stage.
module button_conditioner
  import button_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP_PERIOD     = 25000000
) (
  input logic clk,
  input logic rst,
  button_conditioner_if.slave bus
);
  localparam int DEB_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int STEP_W = cnt_width(STEP_PERIOD);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'((STEP_PERIOD > 0) ? STEP_PERIOD - 1 : 0);

  logic             sync;
  state_t           state_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic             button_q, press_q, release_q, step_q;
  logic             press_d, release_d;

  sync_nff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.button_raw_i),
    .q_o (sync)
  );

  always_comb begin
    press_d   = (state_q == ARMING) && sync  && (deb_cnt_q == DEB_LAST);
    release_d = (state_q == DISARM) && !sync && (deb_cnt_q == DEB_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      deb_cnt_q <= '0;
      button_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      case (state_q)
        IDLE: if (sync) begin
          state_q   <= ARMING;
          deb_cnt_q <= DEB_W'(1);
        end
        ARMING: begin
          if (!sync) state_q <= IDLE;
          else if (press_d) begin
            state_q  <= PRESSED;
            button_q <= 1'b1;
          end else deb_cnt_q <= deb_cnt_q + DEB_W'(1);
        end
        PRESSED: if (!sync) begin
          state_q   <= DISARM;
          deb_cnt_q <= DEB_W'(1);
        end
        DISARM: begin
          if (sync) state_q <= PRESSED;
          else if (release_d) begin
            state_q  <= IDLE;
            button_q <= 1'b0;
          end else deb_cnt_q <= deb_cnt_q + DEB_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  generate
    if (STEP_PERIOD == 0) begin : g_step_level
      // Strobe mirrors the next button level so it lines up with button_q.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) step_q <= 1'b0;
        else     step_q <= press_d | (button_q & ~release_d);
      end
    end else begin : g_step_timer
      logic [STEP_W-1:0] step_cnt_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          step_cnt_q <= '0;
          step_q     <= 1'b0;
        end else if (press_d) begin
          step_cnt_q <= '0;
          step_q     <= 1'b1;
        end else if (button_q && !release_d) begin
          if (step_cnt_q == STEP_LAST) begin
            step_cnt_q <= '0;
            step_q     <= 1'b1;
          end else begin
            step_cnt_q <= step_cnt_q + STEP_W'(1);
            step_q     <= 1'b0;
          end
        end else begin
          step_cnt_q <= '0;
          step_q     <= 1'b0;
        end
      end
    end
  endgenerate

  assign bus.button_o      = button_q;
  assign bus.press_o       = press_q;
  assign bus.release_o     = release_q;
  assign bus.button_step_o = step_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: timed step DUT plus a level-step DUT.
module tb_button_conditioner;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  button_conditioner_if bus_a();
  button_conditioner_if bus_b();

  button_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .STEP_PERIOD(3)) u_dut (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  button_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .STEP_PERIOD(0)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic b, input logic p, input logic r, input logic s);
    check({tag, " button"},  bus_a.button_o,      b);
    check({tag, " press"},   bus_a.press_o,       p);
    check({tag, " release"}, bus_a.release_o,     r);
    check({tag, " step"},    bus_a.button_step_o, s);
  endtask

  initial begin
    rst = 1'b1;
    bus_a.button_raw_i = 1'b0;
    bus_b.button_raw_i = 1'b0;
    repeat (3) tick();
    check_a("reset_a", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_b button", bus_b.button_o, 1'b0);
    check("reset_b step", bus_b.button_step_o, 1'b0);
    rst = 1'b0;
    repeat (2) tick();

    // Clean press, held long enough that the release edge lands on a step slot.
    bus_a.button_raw_i = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      check_a($sformatf("press e%0d", e), e >= 6, e == 6, 1'b0,
              (e >= 6) && ((e - 6) % 3 == 0));
    end
    bus_a.button_raw_i = 1'b0;
    for (int e = 16; e <= 23; e++) begin
      tick();
      check_a($sformatf("release e%0d", e), e < 21, 1'b0, e == 21, e == 18);
    end

    // Bounce shorter than the debounce window.
    for (int i = 0; i < 40; i++) begin
      bus_a.button_raw_i = (i % 4 != 3);
      tick();
      check_a($sformatf("bounce i%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    bus_a.button_raw_i = 1'b0;
    repeat (4) tick();
    check_a("bounce drain", 1'b0, 1'b0, 1'b0, 1'b0);

    // Release bounce while pressed: level and cadence must be undisturbed.
    for (int r = 1; r <= 20; r++) begin
      bus_a.button_raw_i = !(r == 7 || r == 8);
      tick();
      check_a($sformatf("relbounce r%0d", r), r >= 6, r == 6, 1'b0,
              (r >= 6) && ((r - 6) % 3 == 0));
    end
    bus_a.button_raw_i = 1'b0;
    repeat (8) tick();
    check_a("relbounce drain", 1'b0, 1'b0, 1'b0, 1'b0);

    // Async reset while ARMING with deb_cnt=2, then full latency again.
    bus_a.button_raw_i = 1'b1;
    repeat (4) tick();
    #3 rst = 1'b1;
    #1;
    check_a("midreset", 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("postreset e%0d button", e), bus_a.button_o, e >= 6);
      check($sformatf("postreset e%0d press", e),  bus_a.press_o,  e == 6);
    end
    bus_a.button_raw_i = 1'b0;
    repeat (8) tick();

    // STEP_PERIOD=0: step follows the debounced level for a 10-cycle hold.
    for (int e = 1; e <= 18; e++) begin
      bus_b.button_raw_i = (e <= 10);
      tick();
      check($sformatf("level e%0d button", e),  bus_b.button_o,      (e >= 6) && (e <= 15));
      check($sformatf("level e%0d step", e),    bus_b.button_step_o, (e >= 6) && (e <= 15));
      check($sformatf("level e%0d press", e),   bus_b.press_o,       e == 6);
      check($sformatf("level e%0d release", e), bus_b.release_o,     e == 16);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
